led_pwm_fader: RTL
==================

// Module: led_pwm_fader
// PURPOSE
//  Downstream stage of the LED blinker: consumes per-LED on/off requests, drives board LED pins.
//  Replaces hard on/off edges with PWM brightness and linear fade-in/fade-out ramps.
//  Per-channel ceiling set by level_max; one shared PWM counter and one step prescaler.
// PARAMETERS
//  NUM_LEDS  4     number of LED channels
//  PWM_BITS  8     brightness resolution; MAX = 2**PWM_BITS-1 (255)
//  STEP_DIV  4096  clk_in cycles per fade step (one level increment/decrement)
// PORTS
//  clk_in     in   1         system clock, single clock domain
//  rst_in     in   1         asynchronous, active-high reset
//  led_in     in   NUM_LEDS  on/off requests from blinker, synchronous to clk_in
//  level_max  in   PWM_BITS  brightness ceiling for all channels; sampled every cycle
//  led_out    out  NUM_LEDS  PWM-modulated LED drive, registered
//  busy       out  1         1 while any channel is ramping (UP or DOWN), registered
// BEHAVIOUR
//  Reset (async, rst_in=1): pwm_cnt=0, prescaler=0, all levels=0, all states OFF, led_out=0, busy=0.
//  pwm_cnt: free-running 0..MAX-1, wraps to 0; period = MAX cycles (255).
//  step_tick: prescaler counts 0..STEP_DIV-1; one-cycle pulse when it equals STEP_DIV-1, then wraps.
//  led_out[i] <= (lvl_eff[i] > pwm_cnt): 1-cycle latency; level 0 = never on, level MAX = always on.
//  Per-channel FSM, state and level update on the same edge:
//   OFF:  level=0. led_in=1 -> UP.
//   UP:   led_in=0 -> DOWN (no step this cycle). level>=level_max -> ON, level<=level_max.
//         Otherwise, on step_tick: level+1; if level+1==level_max -> ON on that same edge.
//   ON:   led_in=0 -> DOWN. On step_tick: level moves 1 toward level_max (tracks ceiling changes).
//   DOWN: led_in=1 -> UP. On step_tick: level-1; if result==0 -> OFF on that same edge.
//         level already 0 -> OFF next edge regardless of tick.
//  Precedence per cycle: led_in direction change > ceiling check > tick step.
//  Level arithmetic saturates: never below 0, never above MAX; no wrap.
//  level_max=0: UP -> ON next edge with level=0; led_out stays 0.
//  busy <= OR over channels of (state==UP || state==DOWN).
//  rst_in mid-ramp: everything returns to reset values immediately; no ramp resumes after release.
// CONFIGURATION
//  LED_GAMMA_EN defined: lvl_eff = gamma22(level) via 256-entry ROM, round-to-nearest,
//   gamma22(0)=0, gamma22(255)=255; PWM_BITS must be 8 (elaboration error otherwise).
//  LED_GAMMA_EN undefined: lvl_eff = level (linear); no ROM instantiated.
// STRUCTURE
//  Package led_pkg: fade_state_t enum {OFF, UP, ON, DOWN}, PWM_BITS_DEFAULT, gamma22 ROM function.
//  Sub-module led_fade_chan: one channel's FSM + level register, instanced NUM_LEDS times.
//  Top: pwm_cnt, prescaler, compare/output regs, busy reduction.
// TESTING (bench uses STEP_DIV=4, PWM_BITS=8)
//  Reset: rst_in=1 at any time -> led_out=0000, busy=0 with no clock edge required.
//  led_in=0001, level_max=255 -> busy=1 from next edge; ch0 ON after 255 ticks (~1020 cycles), led_out[0] constant 1, busy=0.
//  Hold ch0 ON, level_max=64 -> after 191 ticks level=64; exactly 64 high cycles per 255-cycle period.
//  Ramp reversal: led_in[0]->0 when level=100 in UP -> DOWN; level 0 and OFF after 100 ticks; led_out[0]=0.
//  level_max=0, led_in=1111 -> all ON within 2 cycles, led_out stays 0000, busy pulses at most 1 cycle.
//  LED_GAMMA_EN, steady level=128 -> 56 high cycles per period; without macro -> 128.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED fader; LED_GAMMA_EN adds the gamma-2.2 ROM.
// Pure package: no latency, no flow control.
package led_pkg;

  localparam int PWM_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {OFF, UP, ON, DOWN} fade_state_t;

`ifdef LED_GAMMA_EN
  typedef logic [7:0] gamma_rom_t [256];

  // round(255*(x/255)^2.2) in exact integers: count k with (k+0.5)^5 <= x^11/255^6
  function automatic logic [7:0] gamma22_calc(input int x);
    logic [99:0] lhs, rhs, den, t;
    int g;
    den = 100'd1;
    for (int i = 0; i < 6; i++) den = den * 100'd255;
    lhs = 100'd32;
    for (int i = 0; i < 11; i++) lhs = lhs * 100'(x);
    g = 0;
    for (int k = 0; k < 255; k++) begin
      t   = 100'(2 * k + 1);
      rhs = t * t * t * t * t * den;
      if (rhs <= lhs) g++;
    end
    return 8'(g);
  endfunction

  function automatic gamma_rom_t gamma_rom_build();
    gamma_rom_t rom;
    for (int i = 0; i < 256; i++) rom[i] = gamma22_calc(i);
    return rom;
  endfunction

  localparam gamma_rom_t GAMMA22_ROM = gamma_rom_build();

  function automatic logic [7:0] gamma22(input logic [7:0] lvl);
    return GAMMA22_ROM[lvl];
  endfunction
`endif

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: fade FSM plus brightness level register.
// Level/state update on the edge after inputs; no backpressure.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] level_max,
  input  logic                step_tick,
  output logic [PWM_BITS-1:0] level,
  output logic                ramping
);

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= OFF;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Direction change beats the ceiling check, which beats the tick step.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      OFF: begin
        level_d = '0;
        if (led_in) state_d = UP;
      end
      UP: begin
        if (!led_in) begin
          state_d = DOWN;
        end else if (level_q >= level_max) begin
          state_d = ON;
          level_d = level_max;
        end else if (step_tick) begin
          level_d = level_q + 1'b1;
          if (level_d == level_max) state_d = ON;
        end
      end
      ON: begin
        if (!led_in) begin
          state_d = DOWN;
        end else if (step_tick) begin
          if (level_q < level_max)      level_d = level_q + 1'b1;
          else if (level_q > level_max) level_d = level_q - 1'b1;
        end
      end
      DOWN: begin
        if (led_in) begin
          state_d = UP;
        end else if (level_q == '0) begin
          state_d = OFF;
        end else if (step_tick) begin
          level_d = level_q - 1'b1;
          if (level_d == '0) state_d = OFF;
        end
      end
      default: begin
        state_d = OFF;
        level_d = '0;
      end
    endcase
  end

  assign level   = level_q;
  assign ramping = (state_q == UP) || (state_q == DOWN);

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel PWM LED fader with shared PWM counter and fade prescaler; LED_GAMMA_EN selects gamma-2.2 brightness.
// led_out/busy registered (1-cycle latency from level/state); no backpressure.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = PWM_BITS_DEFAULT,
  parameter int STEP_DIV = 4096
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [PWM_BITS-1:0] level_max,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic                step_tick;
  logic [PWM_BITS-1:0] level   [NUM_LEDS];
  logic [PWM_BITS-1:0] lvl_eff [NUM_LEDS];
  logic [NUM_LEDS-1:0] ramping;
  logic [NUM_LEDS-1:0] pwm_hit;

  assign step_tick = (prescaler == PRE_LAST);

  // PWM period is MAX cycles so level MAX is high on every count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else begin
      pwm_cnt   <= (pwm_cnt == PWM_MAX - 1'b1) ? '0 : pwm_cnt + 1'b1;
      prescaler <= step_tick ? '0 : prescaler + 1'b1;
    end
  end

`ifdef LED_GAMMA_EN
  if (PWM_BITS != 8) begin : g_bad_width
    $error("LED_GAMMA_EN requires PWM_BITS == 8");
  end
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_fade_chan #(.PWM_BITS(PWM_BITS)) u_chan (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .led_in    (led_in[i]),
      .level_max (level_max),
      .step_tick (step_tick),
      .level     (level[i]),
      .ramping   (ramping[i])
    );
`ifdef LED_GAMMA_EN
    assign lvl_eff[i] = PWM_BITS'(gamma22(8'(level[i])));
`else
    assign lvl_eff[i] = level[i];
`endif
    assign pwm_hit[i] = (lvl_eff[i] > pwm_cnt);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      led_out <= '0;
      busy    <= 1'b0;
    end else begin
      led_out <= pwm_hit;
      busy    <= |ramping;
    end
  end

endmodule
